// File: rtl/rggen_rtl_pkg.sv
// Shared register-bus definitions: completion status encoding, access type,
// and small helpers used by the indirect access master.
package rggen_rtl_pkg;

  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'b00,
    RGGEN_EXOKAY       = 2'b01,
    RGGEN_SLAVE_ERROR  = 2'b10,
    RGGEN_DECODE_ERROR = 2'b11
  } rggen_status;

  // Bit 0 set means the access carries write data.
  typedef enum logic [1:0] {
    RGGEN_POSTED_WRITE = 2'b01,
    RGGEN_READ         = 2'b10,
    RGGEN_WRITE        = 2'b11
  } rggen_access;

  // OKAY and EXOKAY both count as success; the error codes share bit 1.
  function automatic logic rggen_status_ok(logic [1:0] status);
    return !status[1];
  endfunction

  function automatic rggen_access rggen_access_from_write(logic write);
    return write ? RGGEN_WRITE : RGGEN_READ;
  endfunction

endpackage

// File: rtl/rggen_indirect_access_master.sv
// Indirect register access initiator: writes the index register, then reads
// or writes the shared data register, and returns one response. The last
// successfully written index is cached so a repeated index can skip the
// index write.
module rggen_indirect_access_master
  import rggen_rtl_pkg::*;
#(
  parameter int                         ADDRESS_WIDTH        = 8,
  parameter int                         BUS_WIDTH            = 32,
  parameter int                         INDEX_WIDTH          = 1,
  parameter logic [ADDRESS_WIDTH-1:0]   INDEX_ADDRESS        = '0,
  parameter logic [ADDRESS_WIDTH-1:0]   DATA_ADDRESS         = '0,
  parameter int                         INDEX_LSB            = 0,
  parameter bit                         SKIP_REDUNDANT_INDEX = 1'b1
)(
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_cmd_valid,
  output logic                     o_cmd_ready,
  input  logic                     i_cmd_write,
  input  logic [INDEX_WIDTH-1:0]   i_cmd_index,
  input  logic [BUS_WIDTH-1:0]     i_cmd_data,
  input  logic [BUS_WIDTH/8-1:0]   i_cmd_strobe,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [BUS_WIDTH-1:0]     o_rsp_data,
  output logic [1:0]               o_rsp_status,
  output logic                     o_bus_valid,
  output logic                     o_bus_write,
  output logic [ADDRESS_WIDTH-1:0] o_bus_address,
  output logic [BUS_WIDTH-1:0]     o_bus_write_data,
  output logic [BUS_WIDTH/8-1:0]   o_bus_strobe,
  input  logic                     i_bus_ready,
  input  logic [1:0]               i_bus_status,
  input  logic [BUS_WIDTH-1:0]     i_bus_read_data
);

  localparam int STRB_W = BUS_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE,
    INDEX,
    DATA,
    RESPOND
  } state_e;

  state_e                 state;
  rggen_access            cmd_access;
  logic [INDEX_WIDTH-1:0] cmd_index_q;
  logic [BUS_WIDTH-1:0]   cmd_data_q;
  logic [STRB_W-1:0]      cmd_strobe_q;
  logic [INDEX_WIDTH-1:0] index_cache;
  logic                   cache_valid;

  logic                   index_hit;
  logic                   data_write;
  logic [BUS_WIDTH-1:0]   data_wdata;
  logic [STRB_W-1:0]      data_strobe;

  // Index value placed at its field position, every other bit zero.
  function automatic logic [BUS_WIDTH-1:0] index_word(logic [INDEX_WIDTH-1:0] idx);
    return BUS_WIDTH'(idx) << INDEX_LSB;
  endfunction

  assign index_hit = SKIP_REDUNDANT_INDEX && cache_valid && (i_cmd_index == index_cache);

  // Data-phase request: taken straight from the command port when the data
  // phase starts from IDLE (index skip), otherwise from the latched command.
  always_comb begin
    data_write  = cmd_access == RGGEN_WRITE;
    data_wdata  = cmd_data_q;
    data_strobe = cmd_strobe_q;
    if (state == IDLE) begin
      data_write  = i_cmd_write;
      data_wdata  = i_cmd_data;
      data_strobe = i_cmd_strobe;
    end
    if (!data_write) begin
      data_strobe = '1;
    end
  end

  // Access sequencer with registered command, bus and response outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state            <= IDLE;
      cmd_access       <= RGGEN_READ;
      cmd_index_q      <= '0;
      cmd_data_q       <= '0;
      cmd_strobe_q     <= '0;
      index_cache      <= '0;
      cache_valid      <= 1'b0;
      o_cmd_ready      <= 1'b1;
      o_rsp_valid      <= 1'b0;
      o_rsp_data       <= '0;
      o_rsp_status     <= '0;
      o_bus_valid      <= 1'b0;
      o_bus_write      <= 1'b0;
      o_bus_address    <= '0;
      o_bus_write_data <= '0;
      o_bus_strobe     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_cmd_valid) begin
            cmd_access   <= rggen_access_from_write(i_cmd_write);
            cmd_index_q  <= i_cmd_index;
            cmd_data_q   <= i_cmd_data;
            cmd_strobe_q <= i_cmd_strobe;
            o_cmd_ready  <= 1'b0;
            o_bus_valid  <= 1'b1;
            if (index_hit) begin
              state            <= DATA;
              o_bus_write      <= data_write;
              o_bus_address    <= DATA_ADDRESS;
              o_bus_write_data <= data_wdata;
              o_bus_strobe     <= data_strobe;
            end else begin
              state            <= INDEX;
              o_bus_write      <= 1'b1;
              o_bus_address    <= INDEX_ADDRESS;
              o_bus_write_data <= index_word(i_cmd_index);
              o_bus_strobe     <= '1;
            end
          end
        end

        INDEX: begin
          if (i_bus_ready) begin
            if (rggen_status_ok(i_bus_status)) begin
              index_cache      <= cmd_index_q;
              cache_valid      <= 1'b1;
              state            <= DATA;
              o_bus_write      <= data_write;
              o_bus_address    <= DATA_ADDRESS;
              o_bus_write_data <= data_wdata;
              o_bus_strobe     <= data_strobe;
            end else begin
              // The index register state is unknown after an error.
              cache_valid      <= 1'b0;
              state            <= RESPOND;
              o_rsp_valid      <= 1'b1;
              o_rsp_status     <= i_bus_status;
              o_rsp_data       <= '0;
              o_bus_valid      <= 1'b0;
              o_bus_write      <= 1'b0;
              o_bus_address    <= '0;
              o_bus_write_data <= '0;
              o_bus_strobe     <= '0;
            end
          end
        end

        DATA: begin
          if (i_bus_ready) begin
            state            <= RESPOND;
            o_rsp_valid      <= 1'b1;
            o_rsp_status     <= i_bus_status;
            o_rsp_data       <= (cmd_access == RGGEN_WRITE) ? '0 : i_bus_read_data;
            o_bus_valid      <= 1'b0;
            o_bus_write      <= 1'b0;
            o_bus_address    <= '0;
            o_bus_write_data <= '0;
            o_bus_strobe     <= '0;
          end
        end

        RESPOND: begin
          if (i_rsp_ready) begin
            state       <= IDLE;
            o_rsp_valid <= 1'b0;
            o_cmd_ready <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rggen_indirect_access_master.sv
// Directed bench: a table of indirect commands with hand-computed bus and
// response expectations, plus reset and mid-access-reset sequences.
module tb_rggen_indirect_access_master;

  localparam logic [7:0] IDX_A = 8'h10;
  localparam logic [7:0] DAT_A = 8'h14;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic        i_cmd_write;
  logic [3:0]  i_cmd_index;
  logic [31:0] i_cmd_data;
  logic [3:0]  i_cmd_strobe;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] o_rsp_data;
  logic [1:0]  o_rsp_status;
  logic        o_bus_valid;
  logic        o_bus_write;
  logic [7:0]  o_bus_address;
  logic [31:0] o_bus_write_data;
  logic [3:0]  o_bus_strobe;
  logic        i_bus_ready;
  logic [1:0]  i_bus_status;
  logic [31:0] i_bus_read_data;

  int n_vec = 0;
  int n_err = 0;

  rggen_indirect_access_master #(
    .ADDRESS_WIDTH(8), .BUS_WIDTH(32), .INDEX_WIDTH(4),
    .INDEX_ADDRESS(IDX_A), .DATA_ADDRESS(DAT_A),
    .INDEX_LSB(0), .SKIP_REDUNDANT_INDEX(1'b1)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_write(i_cmd_write), .i_cmd_index(i_cmd_index),
    .i_cmd_data(i_cmd_data), .i_cmd_strobe(i_cmd_strobe),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_data(o_rsp_data), .o_rsp_status(o_rsp_status),
    .o_bus_valid(o_bus_valid), .o_bus_write(o_bus_write),
    .o_bus_address(o_bus_address), .o_bus_write_data(o_bus_write_data),
    .o_bus_strobe(o_bus_strobe), .i_bus_ready(i_bus_ready),
    .i_bus_status(i_bus_status), .i_bus_read_data(i_bus_read_data)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        write;
    logic [3:0]  index;
    logic [31:0] data;
    logic [3:0]  strobe;
    int          lat;        // cycles each bus phase occupies
    logic [1:0]  idx_st;
    logic [1:0]  dat_st;
    logic [31:0] rdata;
    int          hold;       // cycles i_rsp_ready stays low
    int          exp_idx;    // expected index writes
    int          exp_dat;    // expected data accesses
    logic [3:0]  exp_strobe;
    int          exp_cyc;    // cycle o_rsp_valid first seen
    logic [1:0]  exp_st;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".cmd_ready"}, 32'(o_cmd_ready), 32'd1);
    chk({tag, ".rsp_valid"}, 32'(o_rsp_valid), 32'd0);
    chk({tag, ".bus_valid"}, 32'(o_bus_valid), 32'd0);
    chk({tag, ".bus_write"}, 32'(o_bus_write), 32'd0);
    chk({tag, ".bus_addr"}, 32'(o_bus_address), 32'd0);
    chk({tag, ".bus_wdata"}, o_bus_write_data, 32'd0);
    chk({tag, ".bus_strobe"}, 32'(o_bus_strobe), 32'd0);
    chk({tag, ".rsp_data"}, o_rsp_data, 32'd0);
    chk({tag, ".rsp_status"}, 32'(o_rsp_status), 32'd0);
  endtask

  // Issue one command at a negedge where the DUT is idle, act as the bus
  // target, and check the bus traffic and the response.
  task automatic run_vec(input vec_t v, input string tag);
    int cyc, cnt, n_idx, n_dat, bad, rsp_cyc;
    logic in_phase;
    logic [7:0] a;
    logic w;
    logic [31:0] wd;
    logic [3:0] st;
    logic idx_w;
    logic [31:0] idx_wd;
    logic [3:0] idx_strb;
    logic dat_w;
    logic [31:0] dat_wd;
    logic [3:0] dat_strb;
    logic [31:0] rd;
    logic [1:0] rs;
    cnt = 0; n_idx = 0; n_dat = 0; bad = 0; rsp_cyc = 0; in_phase = 1'b0;
    a = '0; w = 1'b0; wd = '0; st = '0;
    idx_w = 1'b0; idx_wd = '0; idx_strb = '0;
    dat_w = 1'b0; dat_wd = '0; dat_strb = '0;

    chk({tag, ".idle_ready"}, 32'(o_cmd_ready), 32'd1);
    i_cmd_valid  = 1'b1;
    i_cmd_write  = v.write;
    i_cmd_index  = v.index;
    i_cmd_data   = v.data;
    i_cmd_strobe = v.strobe;
    @(posedge i_clk);
    #1;
    i_cmd_valid = 1'b0;

    cyc = 1;
    while (cyc <= 40 && rsp_cyc == 0) begin
      @(negedge i_clk);
      i_bus_ready     = 1'b0;
      i_bus_status    = 2'b00;
      i_bus_read_data = 32'h0BAD_0BAD;
      if (o_cmd_ready) bad++;
      if (o_rsp_valid) begin
        rsp_cyc = cyc;
      end else begin
        if (o_bus_valid) begin
          if (!in_phase) begin
            in_phase = 1'b1;
            cnt = 1;
            a = o_bus_address; w = o_bus_write; wd = o_bus_write_data; st = o_bus_strobe;
            if (a == IDX_A) begin
              if (n_dat != 0) bad++;
              n_idx++; idx_w = w; idx_wd = wd; idx_strb = st;
            end else if (a == DAT_A) begin
              n_dat++; dat_w = w; dat_wd = wd; dat_strb = st;
            end else begin
              bad++;
            end
          end else begin
            cnt++;
            if ({o_bus_address, o_bus_write, o_bus_write_data, o_bus_strobe} !== {a, w, wd, st}) bad++;
          end
          if (cnt == v.lat) begin
            i_bus_ready     = 1'b1;
            i_bus_status    = (a == IDX_A) ? v.idx_st : v.dat_st;
            i_bus_read_data = (a == IDX_A) ? 32'hBAD0_BAD0 : v.rdata;
            in_phase = 1'b0;
          end
        end else if (in_phase) begin
          bad++;
        end
        cyc++;
      end
    end
    i_bus_ready = 1'b0;

    chk({tag, ".index_writes"}, 32'(n_idx), 32'(v.exp_idx));
    chk({tag, ".data_accesses"}, 32'(n_dat), 32'(v.exp_dat));
    if (n_idx != 0) begin
      chk({tag, ".idx_wr"}, 32'(idx_w), 32'd1);
      chk({tag, ".idx_wdata"}, idx_wd, {28'd0, v.index});
      chk({tag, ".idx_strobe"}, 32'(idx_strb), 32'hF);
    end
    if (n_dat != 0) begin
      chk({tag, ".dat_wr"}, 32'(dat_w), 32'(v.write));
      chk({tag, ".dat_strobe"}, 32'(dat_strb), 32'(v.exp_strobe));
      if (v.write) chk({tag, ".dat_wdata"}, dat_wd, v.data);
    end
    chk({tag, ".rsp_cycle"}, 32'(rsp_cyc), 32'(v.exp_cyc));
    if (rsp_cyc == 0) begin
      i_rst = 1'b1;
      @(negedge i_clk);
      i_rst = 1'b0;
    end else begin
      chk({tag, ".rsp_data"}, o_rsp_data, v.exp_rdata);
      chk({tag, ".rsp_status"}, 32'(o_rsp_status), 32'(v.exp_st));
      rd = o_rsp_data; rs = o_rsp_status;
      for (int h = 0; h < v.hold; h++) begin
        i_rsp_ready = 1'b0;
        @(negedge i_clk);
        if (!o_rsp_valid || o_cmd_ready || o_rsp_data !== rd || o_rsp_status !== rs) bad++;
      end
      i_rsp_ready = 1'b1;
      @(negedge i_clk);
      i_rsp_ready = 1'b0;
      chk({tag, ".rsp_done"}, 32'(o_rsp_valid), 32'd0);
      chk({tag, ".ready_back"}, 32'(o_cmd_ready), 32'd1);
    end
    chk({tag, ".protocol"}, 32'(bad), 32'd0);
  endtask

  initial begin
    //         wr    idx    data          strb  lat idx_st dat_st rdata        hold eI eD strobe cyc st     rdata
    vecs[0] = '{1'b0, 4'd3, 32'h0,        4'h0, 1, 2'd0, 2'd0, 32'hCAFEF00D, 0, 1, 1, 4'hF, 3, 2'd0, 32'hCAFEF00D};
    vecs[1] = '{1'b1, 4'd3, 32'h1234,     4'h3, 1, 2'd0, 2'd0, 32'h0,        0, 0, 1, 4'h3, 2, 2'd0, 32'h0};
    vecs[2] = '{1'b1, 4'd5, 32'hAA,       4'hF, 1, 2'd2, 2'd0, 32'h0,        0, 1, 0, 4'h0, 2, 2'd2, 32'h0};
    vecs[3] = '{1'b0, 4'd3, 32'h0,        4'h0, 1, 2'd0, 2'd0, 32'h11111111, 0, 1, 1, 4'hF, 3, 2'd0, 32'h11111111};
    vecs[4] = '{1'b1, 4'd3, 32'h55,       4'hC, 1, 2'd0, 2'd2, 32'h0,        0, 0, 1, 4'hC, 2, 2'd2, 32'h0};
    vecs[5] = '{1'b0, 4'd7, 32'h0,        4'h0, 4, 2'd1, 2'd3, 32'hDEADBEEF, 3, 1, 1, 4'hF, 9, 2'd3, 32'hDEADBEEF};
    vecs[6] = '{1'b0, 4'd7, 32'h0,        4'h5, 1, 2'd0, 2'd1, 32'h76543210, 0, 0, 1, 4'hF, 2, 2'd1, 32'h76543210};
    vecs[7] = '{1'b1, 4'd0, 32'hFFFFFFFF, 4'hF, 1, 2'd3, 2'd0, 32'h0,        0, 1, 0, 4'h0, 2, 2'd3, 32'h0};

    i_rst = 1'b1; i_cmd_valid = 1'b0; i_cmd_write = 1'b0; i_cmd_index = '0;
    i_cmd_data = '0; i_cmd_strobe = '0; i_rsp_ready = 1'b0;
    i_bus_ready = 1'b0; i_bus_status = '0; i_bus_read_data = '0;
    repeat (3) @(negedge i_clk);
    chk_reset_state("reset");
    i_rst = 1'b0;
    @(negedge i_clk);
    chk_reset_state("post_reset");

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], $sformatf("v%0d", i));
      @(negedge i_clk);
    end

    // Reset during the data phase after a successful index write to 9.
    i_cmd_valid = 1'b1; i_cmd_write = 1'b0; i_cmd_index = 4'd9;
    i_cmd_data = '0; i_cmd_strobe = '0;
    @(posedge i_clk);
    #1;
    i_cmd_valid = 1'b0;
    @(negedge i_clk);
    chk("mid.idx_addr", 32'(o_bus_address), 32'(IDX_A));
    i_bus_ready = 1'b1; i_bus_status = 2'd0;
    @(negedge i_clk);
    i_bus_ready = 1'b0;
    chk("mid.dat_valid", 32'(o_bus_valid), 32'd1);
    chk("mid.dat_addr", 32'(o_bus_address), 32'(DAT_A));
    i_rst = 1'b1;
    @(negedge i_clk);
    chk_reset_state("mid_reset");
    i_rst = 1'b0;
    @(negedge i_clk);
    run_vec('{1'b0, 4'd9, 32'h0, 4'h0, 1, 2'd0, 2'd0, 32'hA5A5A5A5, 0,
              1, 1, 4'hF, 3, 2'd0, 32'hA5A5A5A5}, "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
